// File: rtl/sram_arb.sv
// -----------------------------------------------------------------------------
// sram_arb
//
// Two-port round-robin arbiter and sequencer in front of the external 16-bit
// SRAM controller. It picks one requester and latches that request's attributes
// onto the controller interface. It then pulses m_en_o for one cycle and waits
// for the controller to become ready again. On a read it captures the returned
// word into the winner's rdata register, and it acknowledges the winner with a
// one-cycle ack. A BUSY-cycle watchdog aborts transactions that never complete
// and sets a sticky error flag. An aborted transaction is still acknowledged.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   pN_stb_i                   request, held until pN_ack_o
//   pN_we_i, pN_be_i           write enable, byte access
//   pN_addr_i [18:0]           SRAM address
//   pN_wdata_i [31:0]          write data
//   pN_rdata_o [31:0]          read data, valid from ack until next own ack
//   pN_ack_o                   one-cycle completion pulse
//   m_en_o                     controller start pulse (one cycle)
//   m_we_o, m_be_o, m_addr_o,
//   m_wdata_o                  latched attributes of the granted request
//   m_rdata_i [31:0]           controller read data
//   m_rdy_i                    controller idle/ready
//   err_o                      sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module sram_arb #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        p0_stb_i,
   input  logic        p0_we_i,
   input  logic        p0_be_i,
   input  logic [18:0] p0_addr_i,
   input  logic [31:0] p0_wdata_i,
   output logic [31:0] p0_rdata_o,
   output logic        p0_ack_o,
   input  logic        p1_stb_i,
   input  logic        p1_we_i,
   input  logic        p1_be_i,
   input  logic [18:0] p1_addr_i,
   input  logic [31:0] p1_wdata_i,
   output logic [31:0] p1_rdata_o,
   output logic        p1_ack_o,
   output logic        m_en_o,
   output logic        m_we_o,
   output logic        m_be_o,
   output logic [18:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   input  logic [31:0] m_rdata_i,
   input  logic        m_rdy_i,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      DONE
   } state_e;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   state_e      state_q, state_d;
   logic        gnt_q, gnt_d;     // port of the transaction in flight
   logic        last_q, last_d;   // port granted most recently
   logic [7:0]  cnt_q, cnt_d;     // BUSY cycles elapsed
   logic        m_we_q, m_we_d;
   logic        m_be_q, m_be_d;
   logic [18:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        err_q, err_d;
   logic        win;

   // Winner index: p1 wins when it is the sole requester, or on a tie when p0
   // was served last. Otherwise p0 wins.
   assign win = p1_stb_i & (~p0_stb_i | ~last_q);

   always_comb begin
      // NOTE: every variable gets its hold value first, so branches that do
      // not assign it cannot infer a latch.
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      m_we_d    = m_we_q;
      m_be_d    = m_be_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (m_rdy_i && (p0_stb_i || p1_stb_i)) begin
               gnt_d     = win;
               last_d    = win;
               m_we_d    = win ? p1_we_i    : p0_we_i;
               m_be_d    = win ? p1_be_i    : p0_be_i;
               m_addr_d  = win ? p1_addr_i  : p0_addr_i;
               m_wdata_d = win ? p1_wdata_i : p0_wdata_i;
               state_d   = ISSUE;
            end
         end

         ISSUE: begin
            cnt_d   = 8'd0;
            state_d = BUSY;
         end

         BUSY: begin
            cnt_d = cnt_q + 8'd1;
            // cnt_q == 0 marks the first BUSY cycle. The controller may still
            // show stale ready in that cycle, so m_rdy_i is ignored there.
            if ((cnt_q != 8'd0) && m_rdy_i) begin
               if (!m_we_q) begin
                  if (gnt_q) rdata1_d = m_rdata_i;
                  else       rdata0_d = m_rdata_i;
               end
               state_d = DONE;
            end else if (cnt_d == TimeoutCnt) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;   // p0 wins the first tie
         cnt_q     <= 8'd0;
         m_we_q    <= 1'b0;
         m_be_q    <= 1'b0;
         m_addr_q  <= 19'd0;
         m_wdata_q <= 32'd0;
         rdata0_q  <= 32'd0;
         rdata1_q  <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         m_we_q    <= m_we_d;
         m_be_q    <= m_be_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         err_q     <= err_d;
      end
   end

   // Strobes decode directly from the state register, so they are
   // glitch-free and go low immediately on reset.
   assign m_en_o     = (state_q == ISSUE);
   assign p0_ack_o   = (state_q == DONE) & ~gnt_q;
   assign p1_ack_o   = (state_q == DONE) &  gnt_q;
   assign m_we_o     = m_we_q;
   assign m_be_o     = m_be_q;
   assign m_addr_o   = m_addr_q;
   assign m_wdata_o  = m_wdata_q;
   assign p0_rdata_o = rdata0_q;
   assign p1_rdata_o = rdata1_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_sram_arb
//
// Directed bench for sram_arb (TIMEOUT = 10). The SRAM controller is modelled
// inline: per BUSY cycle, m_rdy is either stale-high in the first cycle or
// rises at a chosen cycle. Inputs change 1 time unit after the rising edge,
// and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sram_arb;

   logic        clk;
   logic        rst_n;
   logic        p0_stb, p0_we, p0_be, p0_ack;
   logic [18:0] p0_addr;
   logic [31:0] p0_wdata, p0_rdata;
   logic        p1_stb, p1_we, p1_be, p1_ack;
   logic [18:0] p1_addr;
   logic [31:0] p1_wdata, p1_rdata;
   logic        m_en, m_we, m_be, m_rdy, err;
   logic [18:0] m_addr;
   logic [31:0] m_wdata, m_rdata;

   int n_checks = 0;
   int n_errors = 0;

   sram_arb #(.TIMEOUT(10)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .p0_stb_i   (p0_stb),
      .p0_we_i    (p0_we),
      .p0_be_i    (p0_be),
      .p0_addr_i  (p0_addr),
      .p0_wdata_i (p0_wdata),
      .p0_rdata_o (p0_rdata),
      .p0_ack_o   (p0_ack),
      .p1_stb_i   (p1_stb),
      .p1_we_i    (p1_we),
      .p1_be_i    (p1_be),
      .p1_addr_i  (p1_addr),
      .p1_wdata_i (p1_wdata),
      .p1_rdata_o (p1_rdata),
      .p1_ack_o   (p1_ack),
      .m_en_o     (m_en),
      .m_we_o     (m_we),
      .m_be_o     (m_be),
      .m_addr_o   (m_addr),
      .m_wdata_o  (m_wdata),
      .m_rdata_i  (m_rdata),
      .m_rdy_i    (m_rdy),
      .err_o      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " m_en"},     32'(m_en),    32'd0);
      check({tag, " m_we"},     32'(m_we),    32'd0);
      check({tag, " m_be"},     32'(m_be),    32'd0);
      check({tag, " m_addr"},   32'(m_addr),  32'd0);
      check({tag, " m_wdata"},  m_wdata,      32'd0);
      check({tag, " p0_ack"},   32'(p0_ack),  32'd0);
      check({tag, " p1_ack"},   32'(p1_ack),  32'd0);
      check({tag, " p0_rdata"}, p0_rdata,     32'd0);
      check({tag, " p1_rdata"}, p1_rdata,     32'd0);
      check({tag, " err"},      32'(err),     32'd0);
   endtask

   // Runs one transaction from the current point (request already on the
   // bus) up to and including the ack cycle, where it returns.
   task automatic do_txn(input string tag, input int exp_port,
                         input logic exp_we, input logic exp_be,
                         input logic [18:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic stale, input int ready_at,
                         input logic [31:0] rd, input int exp_busy,
                         input logic drop_stb);
      logic got, done;
      int   stray, extra, nb;
      got = 1'b0; done = 1'b0; stray = 0; extra = 0; nb = -1;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (p0_ack || p1_ack) stray++;
         if (m_en) got = 1'b1;
      end
      check({tag, " m_en seen"},  32'(got),       32'd1);
      check({tag, " m_we"},       32'(m_we),      32'(exp_we));
      check({tag, " m_be"},       32'(m_be),      32'(exp_be));
      check({tag, " m_addr"},     32'(m_addr),    32'(exp_addr));
      check({tag, " m_wdata"},    m_wdata,        exp_wdata);
      check({tag, " stray ack"},  32'(stray),     32'd0);
      m_rdy = 1'b1;   // controller still shows ready during the ISSUE cycle
      for (int i = 1; i <= 40 && !done; i++) begin
         step();
         if (p0_ack || p1_ack) begin
            done = 1'b1;
            nb   = i - 1;
         end else begin
            if (m_en) extra++;
            m_rdy   = (i == 1) ? stale : logic'(i >= ready_at);
            m_rdata = (i >= ready_at) ? rd : 32'h0BAD0BAD;
         end
      end
      check({tag, " ack seen"},    32'(done),   32'd1);
      check({tag, " busy cycles"}, 32'(nb),     32'(exp_busy));
      check({tag, " p0_ack"},      32'(p0_ack), 32'(exp_port == 0));
      check({tag, " p1_ack"},      32'(p1_ack), 32'(exp_port == 1));
      check({tag, " extra m_en"},  32'(extra),  32'd0);
      m_rdy   = 1'b1;
      m_rdata = 32'h0BAD0BAD;
      if (drop_stb) begin
         if (exp_port == 0) p0_stb = 1'b0;
         else               p1_stb = 1'b0;
      end
   endtask

   initial begin
      int n_ack, n_en;
      rst_n = 1'b0;
      p0_stb = 0; p0_we = 0; p0_be = 0; p0_addr = '0; p0_wdata = '0;
      p1_stb = 0; p1_we = 0; p1_be = 0; p1_addr = '0; p1_wdata = '0;
      m_rdy = 1'b1; m_rdata = 32'h0BAD0BAD;

      // Reset state
      #2;
      check_reset_outputs("reset");
      #20;
      rst_n = 1'b1;
      step();

      // Simultaneous requests with continuous re-request: p0, p1, p0, p1
      p0_addr = 19'h00100; p0_wdata = 32'h0000_00AA;
      p1_addr = 19'h00200; p1_wdata = 32'h0000_00BB;
      p0_stb = 1'b1; p1_stb = 1'b1;
      do_txn("tie1", 0, 0, 0, 19'h00100, 32'h0000_00AA, 0, 2, 32'h1111_0001, 2, 0);
      check("tie1 p0_rdata", p0_rdata, 32'h1111_0001);
      check("tie1 p1_rdata", p1_rdata, 32'h0000_0000);
      do_txn("tie2", 1, 0, 0, 19'h00200, 32'h0000_00BB, 0, 2, 32'h1111_0002, 2, 0);
      check("tie2 p0_rdata", p0_rdata, 32'h1111_0001);
      check("tie2 p1_rdata", p1_rdata, 32'h1111_0002);
      do_txn("tie3", 0, 0, 0, 19'h00100, 32'h0000_00AA, 0, 2, 32'h1111_0003, 2, 0);
      check("tie3 p0_rdata", p0_rdata, 32'h1111_0003);
      check("tie3 p1_rdata", p1_rdata, 32'h1111_0002);
      do_txn("tie4", 1, 0, 0, 19'h00200, 32'h0000_00BB, 0, 2, 32'h1111_0004, 2, 1);
      p0_stb = 1'b0;
      check("tie4 p0_rdata", p0_rdata, 32'h1111_0003);
      check("tie4 p1_rdata", p1_rdata, 32'h1111_0004);
      step();
      check("ack one cycle p0", 32'(p0_ack), 32'd0);
      check("ack one cycle p1", 32'(p1_ack), 32'd0);

      // Single read: m_rdy rises 4 cycles after m_en
      p0_we = 1'b0; p0_be = 1'b0; p0_addr = 19'h12345; p0_stb = 1'b1;
      do_txn("read", 0, 0, 0, 19'h12345, 32'h0000_00AA, 0, 4, 32'hDEADBEEF, 4, 1);
      check("read p0_rdata", p0_rdata, 32'hDEADBEEF);
      check("read p1_rdata", p1_rdata, 32'h1111_0004);

      // Write passthrough on p1; read data must not be captured
      p1_we = 1'b1; p1_be = 1'b1; p1_addr = 19'h7C3A5; p1_wdata = 32'h00ABCDEF;
      p1_stb = 1'b1;
      do_txn("write", 1, 1, 1, 19'h7C3A5, 32'h00ABCDEF, 0, 3, 32'h5555_5555, 3, 1);
      check("write p1_rdata", p1_rdata, 32'h1111_0004);
      check("write p0_rdata", p0_rdata, 32'hDEADBEEF);

      // Stale ready: high in BUSY1, low for 3 cycles, rises in BUSY5
      p0_addr = 19'h00042; p0_stb = 1'b1;
      do_txn("stale", 0, 0, 0, 19'h00042, 32'h0000_00AA, 1, 5, 32'hCAFEF00D, 5, 1);
      check("stale p0_rdata", p0_rdata, 32'hCAFEF00D);

      // Timeout: controller never becomes ready; ack after 10 BUSY cycles
      check("err before timeout", 32'(err), 32'd0);
      p1_we = 1'b0; p1_be = 1'b0; p1_addr = 19'h1FFFF; p1_stb = 1'b1;
      do_txn("timeout", 1, 0, 0, 19'h1FFFF, 32'h00ABCDEF, 0, 1000, 32'h7777_7777, 10, 1);
      check("timeout err", 32'(err), 32'd1);
      check("timeout p1_rdata", p1_rdata, 32'h1111_0004);

      // Sticky err across a later successful transaction
      p0_addr = 19'h00001; p0_stb = 1'b1;
      do_txn("sticky", 0, 0, 0, 19'h00001, 32'h0000_00AA, 0, 2, 32'h1212_1212, 2, 1);
      check("sticky err", 32'(err), 32'd1);
      check("sticky p0_rdata", p0_rdata, 32'h1212_1212);

      // Reset mid-BUSY (p0 is the sole requester even though last = p0)
      p0_addr = 19'h00300; p0_stb = 1'b1;
      n_en = 0;
      for (int i = 0; i < 20 && n_en == 0; i++) begin
         step();
         if (m_en) n_en++;
      end
      check("rstbusy m_en seen", 32'(n_en), 32'd1);
      m_rdy = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rstbusy");
      p0_stb = 1'b0;
      m_rdy  = 1'b1;
      #10;
      rst_n = 1'b1;
      n_ack = 0; n_en = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (p0_ack || p1_ack) n_ack++;
         if (m_en) n_en++;
      end
      check("post reset no ack",  32'(n_ack), 32'd0);
      check("post reset no m_en", 32'(n_en),  32'd0);

      // Tie after reset goes to p0
      p0_addr = 19'h00500; p1_addr = 19'h00600; p1_wdata = 32'h0000_00BB;
      p0_stb = 1'b1; p1_stb = 1'b1;
      do_txn("tie after reset", 0, 0, 0, 19'h00500, 32'h0000_00AA, 0, 2, 32'h3434_3434, 2, 1);
      p1_stb = 1'b0;
      check("tie after reset p0_rdata", p0_rdata, 32'h3434_3434);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
